// File: rtl/amp_pga_spi_slave.sv
// Multi-channel programmable-gain-amp SPI slave: oversampled SPI receive,
// gain readback, shutdown-pulse init sequence and sticky protocol-error flags.
module amp_pga_spi_slave #(
    parameter int CHANNELS   = 2,
    parameter int GAIN_W     = 4,
    parameter int VALID_MAX  = 7,
    parameter int FRAME_BITS = CHANNELS * GAIN_W,
    parameter int CNT_W      = $clog2(FRAME_BITS + 2)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         SPI_SCK,
    input  logic                         SPI_MOSI,
    input  logic                         AMP_CS,
    input  logic                         AMP_SHDN,
    input  logic                         ERR_CLR,
    output logic                         AMP_DOUT,
    output logic [CHANNELS*GAIN_W-1:0]   GAIN,
    output logic                         GAIN_VALID,
    output logic                         READY,
    output logic                         ERR_NORESET,
    output logic                         ERR_LEN,
    output logic [CHANNELS-1:0]          ERR_CODE,
    output logic [CNT_W-1:0]             LAST_COUNT
);

    typedef enum logic [1:0] {
        ST_UNINIT,
        ST_SHDN,
        ST_IDLE,
        ST_RECV
    } state_t;

    state_t state, state_n;

    // [0],[1] synchroniser stages, [2] history for edge detection
    logic [2:0] sck_q, cs_q, shdn_q;
    logic [1:0] mosi_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_q  <= '0;
            cs_q   <= '1;
            shdn_q <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], SPI_SCK};
            cs_q   <= {cs_q[1:0], AMP_CS};
            shdn_q <= {shdn_q[1:0], AMP_SHDN};
            mosi_q <= {mosi_q[0], SPI_MOSI};
        end
    end

    logic sck_rise, sck_fall, cs_rise, cs_fall, shdn_rise, shdn_fall;

    assign sck_rise  =  sck_q[1]  & ~sck_q[2];
    assign sck_fall  = ~sck_q[1]  &  sck_q[2];
    assign cs_rise   =  cs_q[1]   & ~cs_q[2];
    assign cs_fall   = ~cs_q[1]   &  cs_q[2];
    assign shdn_rise =  shdn_q[1] & ~shdn_q[2];
    assign shdn_fall = ~shdn_q[1] &  shdn_q[2];

    logic [FRAME_BITS-1:0] in_sr, in_sr_n;
    logic [FRAME_BITS-1:0] out_sr, out_sr_n;
    logic [FRAME_BITS-1:0] gain_n;
    logic [CNT_W-1:0]      cnt, cnt_n, last_n;
    logic                  valid_n, err_nr_n, err_len_n, dout_n;
    logic [CHANNELS-1:0]   err_code_n;
    logic [GAIN_W-1:0]     code;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_UNINIT;
            in_sr       <= '0;
            out_sr      <= '0;
            cnt         <= '0;
            GAIN        <= '0;
            LAST_COUNT  <= '0;
            GAIN_VALID  <= 1'b0;
            ERR_NORESET <= 1'b0;
            ERR_LEN     <= 1'b0;
            ERR_CODE    <= '0;
            AMP_DOUT    <= 1'b0;
        end else begin
            state       <= state_n;
            in_sr       <= in_sr_n;
            out_sr      <= out_sr_n;
            cnt         <= cnt_n;
            GAIN        <= gain_n;
            LAST_COUNT  <= last_n;
            GAIN_VALID  <= valid_n;
            ERR_NORESET <= err_nr_n;
            ERR_LEN     <= err_len_n;
            ERR_CODE    <= err_code_n;
            AMP_DOUT    <= dout_n;
        end
    end

    always_comb begin
        state_n    = state;
        in_sr_n    = in_sr;
        out_sr_n   = out_sr;
        cnt_n      = cnt;
        gain_n     = GAIN;
        last_n     = LAST_COUNT;
        valid_n    = 1'b0;
        err_code_n = ERR_CODE;
        code       = '0;
        // Clear first so that a same-cycle set event below takes priority
        err_nr_n   = ERR_CLR ? 1'b0 : ERR_NORESET;
        err_len_n  = ERR_CLR ? 1'b0 : ERR_LEN;

        if (shdn_rise) begin
            state_n = ST_SHDN;
        end else begin
            case (state)
                ST_UNINIT: begin
                    if (cs_fall) err_nr_n = 1'b1;
                end
                ST_SHDN: begin
                    gain_n   = '0;
                    in_sr_n  = '0;
                    out_sr_n = '0;
                    if (cs_fall)   err_nr_n = 1'b1;
                    if (shdn_fall) state_n  = ST_IDLE;
                end
                ST_IDLE: begin
                    if (cs_fall) begin
                        // Channel CHANNELS-1 already sits at the MSB end of GAIN
                        out_sr_n = GAIN;
                        cnt_n    = '0;
                        state_n  = ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (cs_rise) begin
                        state_n = ST_IDLE;
                        last_n  = cnt;
                        if (cnt == CNT_W'(FRAME_BITS)) begin
                            gain_n  = in_sr;
                            valid_n = 1'b1;
                            for (int unsigned k = 0; k < CHANNELS; k++) begin
                                code          = in_sr[k*GAIN_W +: GAIN_W];
                                err_code_n[k] = (code == '0) || (32'(code) > VALID_MAX);
                            end
                        end else begin
                            err_len_n = 1'b1;
                        end
                    end else if (sck_rise) begin
                        in_sr_n = (in_sr << 1) | FRAME_BITS'(mosi_q[1]);
                        if (cnt != CNT_W'(FRAME_BITS + 1))
                            cnt_n = cnt + CNT_W'(1);
                    end else if (sck_fall) begin
                        out_sr_n = out_sr << 1;
                    end
                end
                default: state_n = ST_UNINIT;
            endcase
        end

        // Driven from next-state values so the first bit is out before any SCK rise
        dout_n = (state_n == ST_RECV && !cs_q[1]) ? out_sr_n[FRAME_BITS-1] : 1'b0;
    end

    assign READY = (state == ST_IDLE) || (state == ST_RECV);

endmodule

// File: tb/tb_amp_pga_spi_slave.sv
// Directed bench for amp_pga_spi_slave: a transaction-level model of the
// 2-channel part is compared every quiet cycle, plus literal spot checks.
module tb_amp_pga_spi_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic cs = 1'b1;
    logic shdn = 1'b0;
    logic err_clr = 1'b0;

    logic        dout1, gv1, ready1, enr1, elen1;
    logic [7:0]  gain1;
    logic [1:0]  ecode1;
    logic [3:0]  last1;

    logic        dout2, gv2, ready2, enr2, elen2;
    logic [11:0] gain2;
    logic [2:0]  ecode2;
    logic [3:0]  last2;

    always #5 clk = ~clk;

    amp_pga_spi_slave #(.CHANNELS(2), .GAIN_W(4), .VALID_MAX(7)) dut (
        .CLK(clk), .RST(rst), .SPI_SCK(sck), .SPI_MOSI(mosi), .AMP_CS(cs),
        .AMP_SHDN(shdn), .ERR_CLR(err_clr), .AMP_DOUT(dout1), .GAIN(gain1),
        .GAIN_VALID(gv1), .READY(ready1), .ERR_NORESET(enr1), .ERR_LEN(elen1),
        .ERR_CODE(ecode1), .LAST_COUNT(last1)
    );

    amp_pga_spi_slave #(.CHANNELS(3), .GAIN_W(4), .VALID_MAX(7)) dut3 (
        .CLK(clk), .RST(rst), .SPI_SCK(sck), .SPI_MOSI(mosi), .AMP_CS(cs),
        .AMP_SHDN(shdn), .ERR_CLR(err_clr), .AMP_DOUT(dout2), .GAIN(gain2),
        .GAIN_VALID(gv2), .READY(ready2), .ERR_NORESET(enr2), .ERR_LEN(elen2),
        .ERR_CODE(ecode2), .LAST_COUNT(last2)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the 2-channel instance
    logic [7:0] m_gain  = '0;
    bit         m_ready = 1'b0;
    bit         m_nr    = 1'b0;
    bit         m_len   = 1'b0;
    logic [1:0] m_code  = '0;
    logic [3:0] m_last  = '0;
    int         m_valid = 0;
    int         valid_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bad_code(input logic [3:0] c);
        return (c == 4'd0) || (c > 4'd7);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shdn_pulse();
        shdn = 1'b1; m_gain = '0; m_ready = 1'b0;
        wait_cyc(8);
        shdn = 1'b0; m_ready = 1'b1;
        wait_cyc(8);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1; m_nr = 1'b0; m_len = 1'b0;
        wait_cyc(1);
        err_clr = 1'b0;
        wait_cyc(8);
    endtask

    // Sends n bits MSB first; abort_at >= 0 raises SHDN before that bit
    task automatic frame(input int n, input logic [15:0] data, input int abort_at,
                         output logic [15:0] rb);
        logic [7:0] snap;
        bit         live;
        logic       exp_bit;
        rb   = '0;
        live = m_ready;
        snap = m_gain;
        cs = 1'b0;
        if (!m_ready) m_nr = 1'b1;
        wait_cyc(6);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                shdn = 1'b1; m_gain = '0; m_ready = 1'b0;
                wait_cyc(6);
                chk("abort_gain", 32'(gain1), 32'h0);
                chk("abort_ready", 32'(ready1), 32'h0);
                cs = 1'b1;
                wait_cyc(6);
                shdn = 1'b0; m_ready = 1'b1;
                wait_cyc(8);
                return;
            end
            exp_bit = 1'b0;
            if (live && i < 8) exp_bit = snap[7-i];
            chk("dout_bit", 32'(dout1), 32'(exp_bit));
            rb = {rb[14:0], dout1};
            mosi = data[n-1-i];
            wait_cyc(4);
            sck = 1'b1;
            wait_cyc(4);
            sck = 1'b0;
            wait_cyc(4);
        end
        mosi = 1'b0;
        wait_cyc(2);
        cs = 1'b1;
        if (live) begin
            m_last = (n > 9) ? 4'd9 : 4'(n);
            if (n == 8) begin
                m_gain = data[7:0];
                m_valid++;
                m_code = {bad_code(data[7:4]), bad_code(data[3:0])};
            end else begin
                m_len = 1'b1;
            end
        end
        wait_cyc(8);
    endtask

    // Model comparison on every cycle where the pins have been quiet long enough
    initial begin
        logic [5:0] prev_pins;
        int         quiet;
        logic       prev_gv;
        prev_pins = '0;
        quiet     = 0;
        prev_gv   = 1'b0;
        forever begin
            @(negedge clk);
            if ({rst, sck, mosi, cs, shdn, err_clr} != prev_pins) quiet = 0;
            else if (quiet < 1000) quiet++;
            prev_pins = {rst, sck, mosi, cs, shdn, err_clr};
            if (!rst) begin
                if (gv1 === 1'b1) valid_seen++;
                if (prev_gv === 1'b1) chk("gv_width", 32'(gv1), 32'h0);
                prev_gv = gv1;
                if (quiet >= 5) begin
                    chk("m_gain", 32'(gain1), 32'(m_gain));
                    chk("m_ready", 32'(ready1), 32'(m_ready));
                    chk("m_err_noreset", 32'(enr1), 32'(m_nr));
                    chk("m_err_len", 32'(elen1), 32'(m_len));
                    chk("m_err_code", 32'(ecode1), 32'(m_code));
                    chk("m_last_count", 32'(last1), 32'(m_last));
                    chk("m_valid_pulses", 32'(valid_seen), 32'(m_valid));
                    if (cs) chk("m_dout_idle", 32'(dout1), 32'h0);
                end
            end else begin
                prev_gv = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rb;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(6);
        chk("rst_gain", 32'(gain1), 32'h0);
        chk("rst_ready", 32'(ready1), 32'h0);
        chk("rst_err_noreset", 32'(enr1), 32'h0);
        chk("rst_err_len", 32'(elen1), 32'h0);
        chk("rst_last", 32'(last1), 32'h0);

        frame(8, 16'h12, -1, rb);
        chk("noinit_err_noreset", 32'(enr1), 32'h1);
        chk("noinit_gain", 32'(gain1), 32'h0);
        chk("noinit_ready", 32'(ready1), 32'h0);
        pulse_err_clr();
        chk("clr_err_noreset", 32'(enr1), 32'h0);

        shdn_pulse();
        chk("init_ready", 32'(ready1), 32'h1);

        frame(8, 16'h12, -1, rb);
        chk("f12_gain", 32'(gain1), 32'h12);
        chk("f12_last", 32'(last1), 32'h8);
        chk("f12_code", 32'(ecode1), 32'h0);

        frame(8, 16'h37, -1, rb);
        chk("f37_readback", 32'(rb[7:0]), 32'h12);
        chk("f37_gain", 32'(gain1), 32'h37);

        frame(7, 16'h5A, -1, rb);
        chk("f7_err_len", 32'(elen1), 32'h1);
        chk("f7_last", 32'(last1), 32'h7);
        frame(10, 16'h2AB, -1, rb);
        chk("f10_last", 32'(last1), 32'h9);
        chk("f10_gain", 32'(gain1), 32'h37);
        pulse_err_clr();
        chk("clr_err_len", 32'(elen1), 32'h0);

        frame(8, 16'h08, -1, rb);
        chk("f08_gain", 32'(gain1), 32'h08);
        chk("f08_code", 32'(ecode1), 32'h3);

        frame(8, 16'h55, 4, rb);
        chk("abort_last", 32'(last1), 32'h8);
        frame(8, 16'h44, -1, rb);
        chk("f44_gain", 32'(gain1), 32'h44);
        chk("f44_code", 32'(ecode1), 32'h0);

        frame(12, 16'h123, -1, rb);
        chk("ch3_gain", 32'(gain2), 32'h123);
        chk("ch3_last", 32'(last2), 32'hC);
        chk("ch3_code", 32'(ecode2), 32'h0);
        chk("ch3_narrow_last", 32'(last1), 32'h9);

        // Reset in the middle of a frame, CS released while reset is held
        cs = 1'b0;
        wait_cyc(6);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1; wait_cyc(4);
            sck = 1'b1;  wait_cyc(4);
            sck = 1'b0;  wait_cyc(4);
        end
        mosi = 1'b0;
        rst = 1'b1;
        m_gain = '0; m_ready = 1'b0; m_nr = 1'b0; m_len = 1'b0; m_code = '0; m_last = '0;
        wait_cyc(3);
        cs = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(8);
        chk("midrst_gain", 32'(gain1), 32'h0);
        chk("midrst_ready", 32'(ready1), 32'h0);
        frame(8, 16'h21, -1, rb);
        chk("midrst_err_noreset", 32'(enr1), 32'h1);
        chk("midrst_frame_gain", 32'(gain1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
